// File: rtl/memory_monitor_v2.sv
// Multi-channel ring-buffer occupancy monitor with sticky overflow/underflow/address errors.
// Define MEM_MON_PEAK_EN to build the per-channel peak-usage registers.
module memory_monitor_v2 #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 18,
  parameter int unsigned LW  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [AW-1:0]     limit,
  input  logic [AW-1:0]     afull_thresh,
  input  logic [NCH*AW-1:0] wr_addr,
  input  logic [NCH*AW-1:0] rd_addr,
  input  logic [NCH*LW-1:0] n1,
  input  logic [NCH*LW-1:0] n2,
  input  logic [NCH-1:0]    err_clr,
  input  logic [NCH-1:0]    peak_clr,
  output logic [NCH*AW-1:0] usage,
  output logic [NCH-1:0]    afull,
  output logic [NCH-1:0]    ovf,
  output logic [NCH-1:0]    udf,
  output logic [NCH-1:0]    addr_err,
  output logic              any_err,
  output logic [NCH*AW-1:0] peak
);

  logic [NCH*AW-1:0] usage_n, usage_q;
  logic [NCH-1:0]    set_ovf, set_udf, set_addr;
  logic [NCH-1:0]    ovf_n, udf_n, addr_n;
  logic [NCH-1:0]    ovf_q, udf_q, addr_q, live_q;
  logic              any_err_q;

  always_comb begin
    logic [AW-1:0]        w, r;
    logic [LW-1:0]        d;
    logic signed [AW+1:0] s;
    logic                 do_clamp;
    usage_n  = '0;
    set_ovf  = '0;
    set_udf  = '0;
    set_addr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w        = wr_addr[i*AW +: AW];
      r        = rd_addr[i*AW +: AW];
      d        = n1[i*LW +: LW] - n2[i*LW +: LW];
      s        = '0;
      do_clamp = 1'b0;
      if (limit != '0) begin
        set_addr[i] = (w >= limit) || (r >= limit);
        if (d == '0) begin
          if (w >= r) begin
            s        = $signed({2'b00, w}) - $signed({2'b00, r});
            do_clamp = 1'b1;
          end else begin
            set_udf[i] = 1'b1;
          end
        end else if (d == LW'(1)) begin
          if (w <= r) begin
            s        = $signed({2'b00, limit}) - $signed({2'b00, r}) + $signed({2'b00, w});
            do_clamp = 1'b1;
          end else begin
            set_ovf[i]            = 1'b1;
            usage_n[i*AW +: AW]   = limit;
          end
        end else if (!d[LW-1]) begin
          set_ovf[i]          = 1'b1;
          usage_n[i*AW +: AW] = limit;
        end else begin
          set_udf[i] = 1'b1;
        end
        // out-of-range addresses can push the wide sum outside [0, limit]
        if (do_clamp) begin
          if (s[AW+1])
            usage_n[i*AW +: AW] = '0;
          else if (s[AW:0] > {1'b0, limit})
            usage_n[i*AW +: AW] = limit;
          else
            usage_n[i*AW +: AW] = s[AW-1:0];
        end
      end
    end
    ovf_n  = ({NCH{en}} & set_ovf)  | (ovf_q  & ~err_clr);
    udf_n  = ({NCH{en}} & set_udf)  | (udf_q  & ~err_clr);
    addr_n = ({NCH{en}} & set_addr) | (addr_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      usage_q   <= '0;
      live_q    <= '0;
      ovf_q     <= '0;
      udf_q     <= '0;
      addr_q    <= '0;
      any_err_q <= 1'b0;
    end else begin
      if (en) begin
        usage_q <= usage_n;
        live_q  <= {NCH{limit != '0}};
      end
      ovf_q     <= ovf_n;
      udf_q     <= udf_n;
      addr_q    <= addr_n;
      any_err_q <= |(ovf_n | udf_n | addr_n);
    end
  end

  // live_q keeps afull low in reset and while the channel is disabled
  always_comb begin
    afull = '0;
    for (int unsigned i = 0; i < NCH; i++)
      afull[i] = live_q[i] && (usage_q[i*AW +: AW] >= afull_thresh);
  end

  assign usage    = usage_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign addr_err = addr_q;
  assign any_err  = any_err_q;

`ifdef MEM_MON_PEAK_EN
  logic [NCH*AW-1:0] peak_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (peak_clr[i])
          peak_q[i*AW +: AW] <= en ? usage_n[i*AW +: AW] : '0;
        else if (en && (usage_n[i*AW +: AW] > peak_q[i*AW +: AW]))
          peak_q[i*AW +: AW] <= usage_n[i*AW +: AW];
      end
    end
  end

  assign peak = peak_q;
`else
  logic peak_clr_unused;
  assign peak_clr_unused = |peak_clr;
  assign peak            = '0;
`endif

endmodule

// File: tb/tb_memory_monitor_v2.sv
// Directed self-checking bench for memory_monitor_v2 (AW=18, LW=16, NCH=4, limit=1000).
module tb_memory_monitor_v2;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 18;
  localparam int unsigned LW  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [AW-1:0]     limit, afull_thresh;
  logic [NCH*AW-1:0] wr_addr, rd_addr;
  logic [NCH*LW-1:0] n1, n2;
  logic [NCH-1:0]    err_clr, peak_clr;
  logic [NCH*AW-1:0] usage, peak;
  logic [NCH-1:0]    afull, ovf, udf, addr_err;
  logic              any_err;

  logic [AW-1:0] w [NCH];
  logic [AW-1:0] r [NCH];
  logic [LW-1:0] a [NCH];
  logic [LW-1:0] b [NCH];

  int errors = 0;
  int checks = 0;

  memory_monitor_v2 #(.NCH(NCH), .AW(AW), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .limit(limit), .afull_thresh(afull_thresh),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .n1(n1), .n2(n2),
    .err_clr(err_clr), .peak_clr(peak_clr),
    .usage(usage), .afull(afull), .ovf(ovf), .udf(udf), .addr_err(addr_err),
    .any_err(any_err), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      wr_addr[i*AW +: AW] = w[i];
      rd_addr[i*AW +: AW] = r[i];
      n1[i*LW +: LW]      = a[i];
      n2[i*LW +: LW]      = b[i];
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] u(input int i);
    return 32'(usage[i*AW +: AW]);
  endfunction

  function automatic logic [31:0] pk(input int i);
    return 32'(peak[i*AW +: AW]);
  endfunction

  function automatic logic [31:0] exp_peak(input logic [31:0] v);
`ifdef MEM_MON_PEAK_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  initial begin
    reset_n = 1'b0; en = 1'b1; limit = 18'd1000; afull_thresh = 18'd900;
    err_clr = '0; peak_clr = '0;
    for (int i = 0; i < NCH; i++) begin w[i] = '0; r[i] = '0; a[i] = '0; b[i] = '0; end
    drive();
    #12;
    chk("reset_usage", usage[31:0], 32'd0);
    chk("reset_flags", {afull, ovf, udf, addr_err, any_err}, 32'd0);
    reset_n = 1'b1;
    #4;

    // S1: basic occupancy, wrapped lap, overflow by two laps, lap-counter wrap
    w[0] = 300; r[0] = 100; a[0] = 5;        b[0] = 5;
    w[1] = 100; r[1] = 900; a[1] = 6;        b[1] = 5;
    w[2] = 0;   r[2] = 0;   a[2] = 7;        b[2] = 5;
    w[3] = 50;  r[3] = 950; a[3] = 16'h0000; b[3] = 16'hFFFF;
    step();
    chk("s1_usage0", u(0), 200);
    chk("s1_afull0", afull[0], 0);
    chk("s1_err0", {ovf[0], udf[0]}, 0);
    chk("s1_usage1", u(1), 200);
    chk("s1_ovf2", ovf[2], 1);
    chk("s1_usage2", u(2), 1000);
    chk("s1_usage3", u(3), 100);
    chk("s1_err3", {ovf[3], udf[3], addr_err[3]}, 0);
    chk("s1_any", any_err, 1);

    // S2: full buffer, ch2 laps restored (ovf sticky)
    w[1] = 400; r[1] = 400;
    a[2] = 5;
    step();
    chk("s2_usage1", u(1), 1000);
    chk("s2_afull1", afull[1], 1);
    chk("s2_ovf1", ovf[1], 0);
    chk("s2_ovf2_sticky", ovf[2], 1);
    chk("s2_usage2", u(2), 0);

    // S3: clear ch2
    err_clr = 4'b0100;
    step();
    chk("s3_ovf2", ovf[2], 0);
    chk("s3_any", any_err, 0);

    // S4: underflow with simultaneous clear; set wins
    err_clr = 4'b1000;
    a[3] = 3; b[3] = 3; w[3] = 100; r[3] = 200;
    step();
    chk("s4_udf3", udf[3], 1);
    chk("s4_usage3", u(3), 0);
    chk("s4_any", any_err, 1);

    // S5: en low holds usage, clear still acts
    en = 1'b0;
    w[0] = 800; w[3] = 200; r[3] = 200;
    step();
    chk("s5_hold0", u(0), 200);
    chk("s5_udf3", udf[3], 0);
    chk("s5_any", any_err, 0);

    // S6/S7: peak tracking sequence 200,700,300
    en = 1'b1; err_clr = '0;
    step();
    chk("s6_usage0", u(0), 700);
    w[0] = 400;
    step();
    chk("s7_usage0", u(0), 300);
    chk("s7_peak0", pk(0), exp_peak(700));
    peak_clr = 4'b0001;
    step();
    chk("s8_peak0", pk(0), exp_peak(300));
    peak_clr = '0;

    // S9: one lap ahead with wr>rd is overflow
    w[1] = 401; r[1] = 400; a[1] = 6; b[1] = 5;
    step();
    chk("s9_ovf1", ovf[1], 1);
    chk("s9_usage1", u(1), 1000);

    // S10: address at limit; usage at threshold
    w[1] = 0; r[1] = 0; a[1] = 5;
    err_clr = 4'b0010;
    w[0] = 1000; r[0] = 100;
    step();
    chk("s10_ovf1", ovf[1], 0);
    chk("s10_addr0", addr_err[0], 1);
    chk("s10_usage0", u(0), 900);
    chk("s10_afull0", afull[0], 1);
    chk("s10_any", any_err, 1);
    err_clr = '0;

    // S11: asynchronous reset mid-run
    #2 reset_n = 1'b0;
    #1;
    chk("s11_usage", usage[31:0], 0);
    chk("s11_flags", {afull, ovf, udf, addr_err, any_err}, 0);
    chk("s11_peak0", pk(0), 0);
    #1 reset_n = 1'b1;
    #1;
    chk("s11_still0", u(0), 0);
    step();
    chk("s11_resume0", u(0), 900);
    chk("s11_addr0", addr_err[0], 1);

    // S12: limit 0 disables channels; clear in the same edge stays clear
    limit = '0; err_clr = 4'b1111;
    step();
    chk("s12_usage", usage[31:0], 0);
    chk("s12_afull", afull, 0);
    chk("s12_addr", addr_err, 0);
    chk("s12_any", any_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
